// File: rtl/verilog_test_4_pkg.sv
// Shared constants and helpers for the 5-input synchronised threshold/parity block.
package verilog_test_4_pkg;

  localparam int unsigned NUM_INPUTS      = 5;
  localparam int unsigned CNT_W           = 3;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_THRESHOLD   = 3;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_INPUTS-1:0] v);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      s = s + CNT_W'(v[i]);
    end
    return s;
  endfunction

endpackage

// File: rtl/verilog_test_4_sync.sv
// Single-bit multi-flop synchroniser with asynchronous active-low clear.
module verilog_test_4_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [Stages-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[Stages-2:0], i_d};
    end
  end

  assign o_q = r_chain[Stages-1];

endmodule

// File: rtl/verilog_test_4.sv
// Synchronises five async inputs, then registers popcount, threshold result, parity
// and a one-cycle change pulse for the threshold result.
module verilog_test_4
  import verilog_test_4_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned THRESHOLD   = DEF_THRESHOLD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  input  logic             E,
  output logic             Y,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             par,
  output logic             y_chg
);

  localparam logic [CNT_W-1:0] ThreshCnt = CNT_W'(THRESHOLD);

  logic [NUM_INPUTS-1:0] w_raw;
  logic [NUM_INPUTS-1:0] w_sync;
  logic [CNT_W-1:0]      w_cnt;
  logic                  w_y;
  logic                  w_par;

  logic                  r_y;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_par;
  logic                  r_y_chg;

  assign w_raw = {A, B, C, D, E};

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_sync
    verilog_test_4_sync #(
      .Stages(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .i_d  (w_raw[gi]),
      .o_q  (w_sync[gi])
    );
  end

  assign w_cnt = popcount(w_sync);
  assign w_y   = (w_cnt >= ThreshCnt);
  assign w_par = ^w_sync;

  // All results share one register stage so they always update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= 1'b0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_y_chg <= 1'b0;
    end else begin
      r_y     <= w_y;
      r_cnt   <= w_cnt;
      r_par   <= w_par;
      r_y_chg <= (w_y != r_y);
    end
  end

  assign Y        = r_y;
  assign ones_cnt = r_cnt;
  assign par      = r_par;
  assign y_chg    = r_y_chg;

endmodule

// File: tb/tb_verilog_test_4.sv
// Directed self-checking bench: default instance plus THRESHOLD=1 and =5 instances.
module tb_verilog_test_4;

  logic       clk;
  logic       rst_n;
  logic [4:0] vec;

  logic       y, par, chg;
  logic [2:0] cnt;
  logic       y_t1, par_t1, chg_t1;
  logic [2:0] cnt_t1;
  logic       y_t5, par_t5, chg_t5;
  logic [2:0] cnt_t5;

  int n_total = 0;
  int n_bad   = 0;
  logic [2:0] last_cnt = 3'd0;

  verilog_test_4 u_dut (
    .clk(clk), .rst_n(rst_n),
    .A(vec[4]), .B(vec[3]), .C(vec[2]), .D(vec[1]), .E(vec[0]),
    .Y(y), .ones_cnt(cnt), .par(par), .y_chg(chg)
  );

  verilog_test_4 #(.SYNC_STAGES(2), .THRESHOLD(1)) u_dut_t1 (
    .clk(clk), .rst_n(rst_n),
    .A(vec[4]), .B(vec[3]), .C(vec[2]), .D(vec[1]), .E(vec[0]),
    .Y(y_t1), .ones_cnt(cnt_t1), .par(par_t1), .y_chg(chg_t1)
  );

  verilog_test_4 #(.SYNC_STAGES(2), .THRESHOLD(5)) u_dut_t5 (
    .clk(clk), .rst_n(rst_n),
    .A(vec[4]), .B(vec[3]), .C(vec[2]), .D(vec[1]), .E(vec[0]),
    .Y(y_t5), .ones_cnt(cnt_t5), .par(par_t5), .y_chg(chg_t5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a vector at a falling edge, confirm nothing moves for two edges, new values on
  // the third, and that y_chg drops again on the fourth.
  task automatic apply_vec(input logic [4:0] v, input logic exp_y, input logic [2:0] exp_cnt,
                           input logic exp_par, input logic exp_pulse);
    @(negedge clk);
    vec = v;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      check_eq($sformatf("hold_cnt_%b_e%0d", v, k), 32'(cnt), 32'(last_cnt));
      check_eq($sformatf("hold_chg_%b_e%0d", v, k), 32'(chg), 32'd0);
    end
    @(posedge clk); #1;
    check_eq($sformatf("cnt_%b", v), 32'(cnt), 32'(exp_cnt));
    check_eq($sformatf("y_%b", v),   32'(y),   32'(exp_y));
    check_eq($sformatf("par_%b", v), 32'(par), 32'(exp_par));
    check_eq($sformatf("chg_%b", v), 32'(chg), 32'(exp_pulse));
    @(posedge clk); #1;
    check_eq($sformatf("chg_drop_%b", v), 32'(chg), 32'd0);
    check_eq($sformatf("y_stable_%b", v), 32'(y),   32'(exp_y));
    last_cnt = exp_cnt;
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      check_eq($sformatf("%s_chg_%0d", tag, k), 32'(chg), 32'd0);
      check_eq($sformatf("%s_y_%0d", tag, k),   32'(y),   32'd0);
      check_eq($sformatf("%s_cnt_%0d", tag, k), 32'(cnt), 32'd0);
    end
  endtask

  initial begin
    int pc;
    vec   = 5'b00000;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_y",   32'(y),   32'd0);
    check_eq("rst_cnt", 32'(cnt), 32'd0);
    check_eq("rst_par", 32'(par), 32'd0);
    check_eq("rst_chg", 32'(chg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_quiet("idle", 6);

    apply_vec(5'b10101, 1'b1, 3'd3, 1'b1, 1'b1);
    apply_vec(5'b11011, 1'b1, 3'd4, 1'b0, 1'b0);
    apply_vec(5'b11111, 1'b1, 3'd5, 1'b1, 1'b0);
    apply_vec(5'b01010, 1'b0, 3'd2, 1'b0, 1'b1);
    apply_vec(5'b11100, 1'b1, 3'd3, 1'b1, 1'b1);

    // Async reset between edges with Y=1 and a falling vector already in flight.
    @(negedge clk);
    vec = 5'b00011;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_y",    32'(y),    32'd0);
    check_eq("arst_cnt",  32'(cnt),  32'd0);
    check_eq("arst_par",  32'(par),  32'd0);
    check_eq("arst_chg",  32'(chg),  32'd0);
    check_eq("arst_y_t1", 32'(y_t1), 32'd0);
    vec = 5'b00000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_cnt = 3'd0;
    check_quiet("post_rst", 6);
    apply_vec(5'b11100, 1'b1, 3'd3, 1'b1, 1'b1);

    for (int v = 0; v < 32; v++) begin
      @(negedge clk);
      vec = 5'(v);
      repeat (3) @(posedge clk);
      #1;
      pc = $countones(5'(v));
      check_eq($sformatf("sw_cnt_%0d", v), 32'(cnt),  32'(pc));
      check_eq($sformatf("sw_par_%0d", v), 32'(par),  32'(pc % 2));
      check_eq($sformatf("sw_y3_%0d", v),  32'(y),    32'(pc >= 3));
      check_eq($sformatf("sw_y1_%0d", v),  32'(y_t1), 32'(pc >= 1));
      check_eq($sformatf("sw_y5_%0d", v),  32'(y_t5), 32'(pc >= 5));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
